// File: rtl/dds_wave_gen.sv
// Two-tone direct digital synthesiser with a shared quarter-wave sine table.
// Tuning words, mode and scale are shadowed and take effect at a tone-1 phase
// wrap, so a frequency change always starts from phase zero. The quarter-wave
// table T[i] = round(M*sin(pi*i/(2*Q))) is built at elaboration time with
// fixed-point arithmetic, so no external memory image is needed.
module dds_wave_gen #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_en,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [PHASE_W-1:0]       f1_set,
    input  logic [PHASE_W-1:0]       f2_set,
    input  logic [2:0]               w_set,
    input  logic                     a_set,
    output logic signed [DATA_W:0]   wave,
    output logic                     wave_valid
);

    localparam int    Q       = 2 ** (ADDR_W - 2);
    localparam int    M       = 2 ** (DATA_W - 1) - 1;
    localparam int    RA_W    = ADDR_W - 1;
    localparam longint PI_Q30 = 64'sd3373259426;

    // round(M*sin(pi*i/(2Q))) via a Q30 Taylor series of sin(x), x in [0, pi/2]
    function automatic longint qsin_val(input int i);
        longint x, x2, term, sum;
        x    = (PI_Q30 * i) / (2 * Q);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = (term * x2) >>> 30;
            term = -(term / ((2 * n) * (2 * n + 1)));
            sum  = sum + term;
        end
        return (longint'(M) * sum + (64'sd1 <<< 29)) >>> 30;
    endfunction

    // quarter-wave mirroring: returns {negate, table address}
    function automatic logic [RA_W:0] lut_index(input logic [ADDR_W-1:0] p);
        logic [RA_W-1:0] ad;
        if (p[ADDR_W-2]) ad = RA_W'(Q) - {1'b0, p[ADDR_W-3:0]};
        else             ad = {1'b0, p[ADDR_W-3:0]};
        return {p[ADDR_W-1], ad};
    endfunction

    logic signed [DATA_W-1:0] rom [0:Q];
    for (genvar gi = 0; gi <= Q; gi++) begin : g_rom
        localparam logic signed [DATA_W-1:0] TV = DATA_W'(qsin_val(gi));
        assign rom[gi] = TV;
    end

    // config and accumulator state
    logic [PHASE_W-1:0] acc1_q, acc1_d, acc2_q, acc2_d;
    logic [PHASE_W-1:0] f1_q, f1_d, f2_q, f2_d, sh_f1_q, sh_f1_d, sh_f2_q, sh_f2_d;
    logic [2:0]         w_q, w_d, sh_w_q, sh_w_d;
    logic               a_q, a_d, sh_a_q, sh_a_d, pend_q, pend_d, wrap_q, wrap_d;
    logic [PHASE_W:0]   sum1;
    logic               apply;
    // pipeline state: E0 phase, E1 index, E2 table, E3 signed, E4 output
    logic [ADDR_W-1:0]  ph1_q, ph1_d, ph2_q, ph2_d;
    logic [2:0]         w0_q, w0_d;
    logic               a0_q, a0_d, v0_q, v0_d;
    logic [RA_W-1:0]    ad1_q, ad1_d, ad2_q, ad2_d;
    logic               ng1_q, ng1_d, ng2_q, ng2_d, two1_q, two1_d, a1_q, a1_d, v1_q, v1_d;
    logic               cos1, cos2, two;
    logic [RA_W:0]      ix1, ix2;
    logic signed [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d, s1_q, s1_d, s2_q, s2_d;
    logic               ng1b_q, ng1b_d, ng2b_q, ng2b_d, two2_q, two2_d, a2_q, a2_d, v2_q, v2_d;
    logic               two3_q, two3_d, a3_q, a3_d, v3_q, v3_d;
    logic signed [DATA_W:0] t, wave_q, wave_d;
    logic               wave_valid_q, wave_valid_d;

    assign cfg_ready  = ~pend_q;
    assign wave       = wave_q;
    assign wave_valid = wave_valid_q;

    // E0: config handshake, glitch-free apply at wrap, phase capture
    always_comb begin
        acc1_d  = acc1_q;   acc2_d  = acc2_q;
        f1_d    = f1_q;     f2_d    = f2_q;   w_d = w_q;   a_d = a_q;
        sh_f1_d = sh_f1_q;  sh_f2_d = sh_f2_q; sh_w_d = sh_w_q; sh_a_d = sh_a_q;
        pend_d  = pend_q;   wrap_d  = wrap_q;
        ph1_d   = ph1_q;    ph2_d   = ph2_q;  w0_d = w0_q; a0_d = a0_q;
        v0_d    = s_en;
        sum1    = {1'b0, acc1_q} + {1'b0, f1_q};
        apply   = s_en & pend_q & (wrap_q | (f1_q == '0));
        if (cfg_valid && !pend_q) begin
            sh_f1_d = f1_set;  sh_f2_d = f2_set;  sh_w_d = w_set;  sh_a_d = a_set;
            pend_d  = 1'b1;
        end
        if (apply) begin
            f1_d   = sh_f1_q;  f2_d = sh_f2_q;  w_d = sh_w_q;  a_d = sh_a_q;
            pend_d = 1'b0;
            ph1_d  = '0;       ph2_d = '0;
            acc1_d = sh_f1_q;  acc2_d = sh_f2_q;
            wrap_d = 1'b0;
            w0_d   = sh_w_q;   a0_d = sh_a_q;
        end else if (s_en) begin
            ph1_d  = acc1_q[PHASE_W-1 -: ADDR_W];
            ph2_d  = acc2_q[PHASE_W-1 -: ADDR_W];
            acc1_d = sum1[PHASE_W-1:0];
            wrap_d = sum1[PHASE_W];
            acc2_d = acc2_q + f2_q;
            w0_d   = w_q;      a0_d = a_q;
        end
    end

    // E1..E4: mode decode, table lookup, mirror/sign, combine and scale
    always_comb begin
        cos1 = 1'b0; cos2 = 1'b0; two = 1'b0;
        case (w0_q)
            3'b001:  cos1 = 1'b1;
            3'b010:  two  = 1'b1;
            3'b011:  begin two = 1'b1; cos2 = 1'b1; end
            3'b100:  begin two = 1'b1; cos1 = 1'b1; cos2 = 1'b1; end
            default: ;
        endcase
        ix1    = lut_index(ph1_q + (cos1 ? ADDR_W'(Q) : '0));
        ix2    = lut_index(ph2_q + (cos2 ? ADDR_W'(Q) : '0));
        ng1_d  = ix1[RA_W];  ad1_d = ix1[RA_W-1:0];
        ng2_d  = ix2[RA_W];  ad2_d = ix2[RA_W-1:0];
        two1_d = two;  a1_d = a0_q;  v1_d = v0_q;

        r1_d   = rom[ad1_q];  r2_d = rom[ad2_q];
        ng1b_d = ng1_q;  ng2b_d = ng2_q;  two2_d = two1_q;  a2_d = a1_q;  v2_d = v1_q;

        s1_d   = ng1b_q ? -r1_q : r1_q;
        s2_d   = ng2b_q ? -r2_q : r2_q;
        two3_d = two2_q;  a3_d = a2_q;  v3_d = v2_q;

        if (two3_q) t = {s1_q[DATA_W-1], s1_q} + {s2_q[DATA_W-1], s2_q};
        else        t = {s1_q, 1'b0};
        wave_d       = v3_q ? (a3_q ? t : (t >>> 1)) : wave_q;
        wave_valid_d = v3_q;
    end

    // state and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            acc1_q <= '0; acc2_q <= '0; f1_q <= '0; f2_q <= '0; w_q <= '0; a_q <= 1'b0;
            sh_f1_q <= '0; sh_f2_q <= '0; sh_w_q <= '0; sh_a_q <= 1'b0;
            pend_q <= 1'b0; wrap_q <= 1'b0;
            ph1_q <= '0; ph2_q <= '0; w0_q <= '0; a0_q <= 1'b0; v0_q <= 1'b0;
            ad1_q <= '0; ad2_q <= '0; ng1_q <= 1'b0; ng2_q <= 1'b0;
            two1_q <= 1'b0; a1_q <= 1'b0; v1_q <= 1'b0;
            r1_q <= '0; r2_q <= '0; ng1b_q <= 1'b0; ng2b_q <= 1'b0;
            two2_q <= 1'b0; a2_q <= 1'b0; v2_q <= 1'b0;
            s1_q <= '0; s2_q <= '0; two3_q <= 1'b0; a3_q <= 1'b0; v3_q <= 1'b0;
            wave_q <= '0; wave_valid_q <= 1'b0;
        end else begin
            acc1_q <= acc1_d; acc2_q <= acc2_d; f1_q <= f1_d; f2_q <= f2_d; w_q <= w_d; a_q <= a_d;
            sh_f1_q <= sh_f1_d; sh_f2_q <= sh_f2_d; sh_w_q <= sh_w_d; sh_a_q <= sh_a_d;
            pend_q <= pend_d; wrap_q <= wrap_d;
            ph1_q <= ph1_d; ph2_q <= ph2_d; w0_q <= w0_d; a0_q <= a0_d; v0_q <= v0_d;
            ad1_q <= ad1_d; ad2_q <= ad2_d; ng1_q <= ng1_d; ng2_q <= ng2_d;
            two1_q <= two1_d; a1_q <= a1_d; v1_q <= v1_d;
            r1_q <= r1_d; r2_q <= r2_d; ng1b_q <= ng1b_d; ng2b_q <= ng2b_d;
            two2_q <= two2_d; a2_q <= a2_d; v2_q <= v2_d;
            s1_q <= s1_d; s2_q <= s2_d; two3_q <= two3_d; a3_q <= a3_d; v3_q <= v3_d;
            wave_q <= wave_d; wave_valid_q <= wave_valid_d;
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: a behavioural model of the accumulators,
// config shadowing and wrap-gated apply predicts each sample (using real sin)
// and the cycle it must appear on; a monitor pops and compares on wave_valid.
module tb_dds_wave_gen;

    localparam real         PI  = 3.14159265358979323846;
    localparam int          M   = 2047;
    localparam logic [31:0] QTR = 32'h4000_0000;

    logic               clk = 1'b0;
    logic               rst, s_en, cfg_valid, cfg_ready, a_set, wave_valid;
    logic [31:0]        f1_set, f2_set;
    logic [2:0]         w_set;
    logic signed [12:0] wave;

    always #5 clk = ~clk;

    dds_wave_gen dut (
        .clk(clk), .rst(rst), .s_en(s_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .f1_set(f1_set), .f2_set(f2_set), .w_set(w_set), .a_set(a_set),
        .wave(wave), .wave_valid(wave_valid)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_samp = 0;

    typedef struct { int due; int val; int idx; } exp_t;
    exp_t sb[$];

    logic [31:0] m_acc1, m_acc2, m_f1, m_f2, sh_f1, sh_f2;
    logic [2:0]  m_w, sh_w;
    logic        m_a, sh_a, m_pend, m_wrap;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // output monitor: each pulse must match the scoreboard head on its due cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check($sformatf("valid#%0d", sb[0].idx), wave_valid, 1);
                check($sformatf("wave#%0d", sb[0].idx), wave, sb[0].val);
                void'(sb.pop_front());
            end else if (wave_valid) begin
                check("stray_valid", wave_valid, 0);
            end
        end
    end

    function automatic int tone(input logic [31:0] ph);
        int  p;
        real r;
        p = int'(ph[31:20]);
        r = M * $sin(2.0 * PI * p / 4096.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    task automatic model_reset();
        m_acc1 = 0; m_acc2 = 0; m_f1 = 0; m_f2 = 0; sh_f1 = 0; sh_f2 = 0;
        m_w = 0; sh_w = 0; m_a = 0; sh_a = 0; m_pend = 0; m_wrap = 0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_sample();
        logic [31:0] p1, p2;
        logic [32:0] sum;
        int t, v;
        s_en = 1'b1;
        if (m_pend && (m_wrap || m_f1 == 0)) begin
            m_f1 = sh_f1; m_f2 = sh_f2; m_w = sh_w; m_a = sh_a; m_pend = 0;
            p1 = 0; p2 = 0; m_acc1 = m_f1; m_acc2 = m_f2; m_wrap = 0;
        end else begin
            p1 = m_acc1; p2 = m_acc2;
            sum = {1'b0, m_acc1} + {1'b0, m_f1};
            m_acc1 = sum[31:0]; m_wrap = sum[32];
            m_acc2 = m_acc2 + m_f2;
        end
        case (m_w)
            3'b001:  t = 2 * tone(p1 + QTR);
            3'b010:  t = tone(p1) + tone(p2);
            3'b011:  t = tone(p1) + tone(p2 + QTR);
            3'b100:  t = tone(p1 + QTR) + tone(p2 + QTR);
            default: t = 2 * tone(p1);
        endcase
        v = m_a ? t : (t >>> 1);
        sb.push_back('{cyc + 5, v, n_samp});
        n_samp++;
        tick();
        s_en = 1'b0;
        check("cfg_ready_after_sample", cfg_ready, !m_pend);
    endtask

    task automatic spaced_samples(input int n);
        for (int i = 0; i < n; i++) begin
            do_sample();
            tick(3);
        end
    endtask

    task automatic offer(input logic [31:0] f1, input logic [31:0] f2,
                         input logic [2:0] w, input logic a);
        check("cfg_ready_before_offer", cfg_ready, !m_pend);
        cfg_valid = 1'b1; f1_set = f1; f2_set = f2; w_set = w; a_set = a;
        if (!m_pend) begin
            sh_f1 = f1; sh_f2 = f2; sh_w = w; sh_a = a; m_pend = 1;
        end
        tick();
        cfg_valid = 1'b0;
        f1_set = $urandom; f2_set = $urandom; w_set = 3'($urandom); a_set = 1'($urandom);
        check("cfg_ready_after_accept", cfg_ready, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; s_en = 1'b0; cfg_valid = 1'b0;
        f1_set = 0; f2_set = 0; w_set = 0; a_set = 0;
        model_reset();
        tick(3);
        check("rst_wave", wave, 0);
        check("rst_valid", wave_valid, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        rst = 1'b0;
        tick(2);

        // T1: single sine, full scale
        offer(32'h4000_0000, 0, 3'b000, 1'b1);
        spaced_samples(8);
        // T2: cosine, half scale
        offer(32'h4000_0000, 0, 3'b001, 1'b0);
        spaced_samples(8);
        // T3: sin1 + cos2
        offer(32'h4000_0000, 32'h4000_0000, 3'b011, 1'b1);
        spaced_samples(8);
        // T4: slow tone, new config offered at sample 5 waits for the wrap
        offer(32'h1000_0000, 0, 3'b000, 1'b1);
        spaced_samples(5);
        offer(32'h4000_0000, 0, 3'b000, 1'b1);
        spaced_samples(15);
        // T5: back-to-back samples
        for (int i = 0; i < 20; i++) do_sample();
        tick(8);

        // T6: reset with three samples in flight and a config pending
        do_sample();
        tick(6);
        offer(32'h0800_0000, 32'h0100_0000, 3'b010, 1'b0);
        for (int i = 0; i < 3; i++) do_sample();
        check("t6_pending_held", cfg_ready, 0);
        sb.delete();
        rst = 1'b1;
        tick();
        check("t6_rst_wave", wave, 0);
        check("t6_rst_valid", wave_valid, 0);
        check("t6_rst_cfg_ready", cfg_ready, 1);
        rst = 1'b0;
        model_reset();
        tick(10);

        // after reset: two-tone interior table values, then a reserved mode
        offer(32'h2000_0000, 32'h0800_0000, 3'b100, 1'b0);
        spaced_samples(8);
        offer(32'h4000_0000, 32'd5, 3'b111, 1'b1);
        spaced_samples(6);

        tick(8);
        check("drain_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
